// File: rtl/core_bus_responder_pkg.sv
// Shared encodings, FSM state and transaction record for the core bus responder.
// Bus width constants sit next to the register-bus widths used elsewhere in the core.
package core_bus_responder_pkg;

    localparam int REG_BUS_AW = 64;
    localparam int REG_BUS_DW = 64;
    localparam int BUS_W      = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] REQ_READ  = 2'b00;
    localparam logic [1:0] REQ_WRITE = 2'b01;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT, ST_RESP
    } state_e;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

    typedef struct packed {
        port_e            port;
        logic [BUS_W-1:0] addr;
        logic [1:0]       size;
        logic [1:0]       op;
        logic [BUS_W-1:0] wdata;
    } txn_t;

    function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            SIZE_B:  is_aligned = 1'b1;
            SIZE_H:  is_aligned = (off[0] == 1'b0);
            SIZE_W:  is_aligned = (off[1:0] == 2'b00);
            default: is_aligned = (off == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/core_bus_responder_bus_lane_align.sv
// Byte-lane steering between right-justified core data and the lane-aligned 64-bit RAM bus.
module bus_lane_align
    import core_bus_responder_pkg::*;
(
    input  logic [2:0]       off,
    input  logic [1:0]       size,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [BUS_W-1:0] rdata_i,
    output logic [7:0]       wstrb_o,
    output logic [BUS_W-1:0] wdata_o,
    output logic [BUS_W-1:0] rdata_o
);

    logic [5:0]       shamt;
    logic [7:0]       strb_base;
    logic [BUS_W-1:0] mask;

    assign shamt = {off, 3'b000};

    always_comb begin
        strb_base = 8'hff;
        mask      = '1;
        case (size)
            SIZE_B:  begin strb_base = 8'h01; mask = 64'h0000_0000_0000_00ff; end
            SIZE_H:  begin strb_base = 8'h03; mask = 64'h0000_0000_0000_ffff; end
            SIZE_W:  begin strb_base = 8'h0f; mask = 64'h0000_0000_ffff_ffff; end
            default: begin strb_base = 8'hff; mask = '1; end
        endcase
        wstrb_o = strb_base << off;
        wdata_o = wdata_i << shamt;
        rdata_o = (rdata_i >> shamt) & mask;
    end

endmodule

// File: rtl/core_bus_responder.sv
// Round-robin responder for the core fetch and data ports onto a single RAM backend.
// One transaction in flight; window/alignment errors are answered without touching the RAM.
module core_bus_responder
    import core_bus_responder_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] ADDR_SIZE = 64'h0000_0000_0800_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [63:0]       if_addr,
    input  logic [1:0]        if_size,
    output logic              if_ready,
    output logic [1:0]        if_resp,
    output logic [63:0]       if_data_read,
    input  logic              mem_valid,
    input  logic [1:0]        mem_req,
    input  logic [63:0]       mem_addr,
    input  logic [63:0]       mem_data_write,
    input  logic [1:0]        mem_size,
    output logic              mem_ready,
    output logic [1:0]        mem_resp,
    output logic [63:0]       mem_data_read,
    output logic              ram_req,
    output logic              ram_we,
    output logic [63:0]       ram_addr,
    output logic [63:0]       ram_wdata,
    output logic [7:0]        ram_wstrb,
    input  logic              ram_gnt,
    input  logic              ram_rvalid,
    input  logic [63:0]       ram_rdata,
    input  logic              ram_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    port_e            last_q, last_d;
    txn_t             txn_q, txn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       res_resp_q, res_resp_d;
    logic [63:0]      res_data_q, res_data_d;
    logic [1:0]       if_resp_q, if_resp_d, mem_resp_q, mem_resp_d;
    logic [63:0]      if_data_q, if_data_d, mem_data_q, mem_data_d;

    logic             pick_mem, in_window, bad_op, timed_out;
    logic [7:0]       lane_strb;
    logic [63:0]      lane_wdata, lane_rdata;

    bus_lane_align u_align (
        .off     (txn_q.addr[2:0]),
        .size    (txn_q.size),
        .wdata_i (txn_q.wdata),
        .rdata_i (ram_rdata),
        .wstrb_o (lane_strb),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    // Subtract before comparing so the upper bound cannot overflow.
    assign in_window = (txn_q.addr >= ADDR_BASE) && ((txn_q.addr - ADDR_BASE) < ADDR_SIZE);
    assign bad_op    = (txn_q.op != REQ_READ) && (txn_q.op != REQ_WRITE);
    assign pick_mem  = mem_valid && (!if_valid || (last_q == PORT_IF));
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (if_valid || mem_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = (!in_window || !is_aligned(txn_q.addr[2:0], txn_q.size) || bad_op)
                                ? ST_RESP : ST_REQ;
            ST_REQ:   if (ram_gnt) state_d = ST_WAIT;
            ST_WAIT:  if (ram_rvalid || timed_out) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        txn_d      = txn_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        res_resp_d = res_resp_q;
        res_data_d = res_data_q;
        if_resp_d  = if_resp_q;
        if_data_d  = if_data_q;
        mem_resp_d = mem_resp_q;
        mem_data_d = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (if_valid || mem_valid) begin
                    txn_d.port  = pick_mem ? PORT_MEM : PORT_IF;
                    txn_d.addr  = pick_mem ? mem_addr : if_addr;
                    txn_d.size  = pick_mem ? mem_size : if_size;
                    txn_d.op    = pick_mem ? mem_req : REQ_READ;
                    txn_d.wdata = pick_mem ? mem_data_write : '0;
                end
            end
            ST_CHECK: begin
                res_data_d = '0;
                if (!in_window) begin
                    res_resp_d = RESP_DECERR;
                end else if (!is_aligned(txn_q.addr[2:0], txn_q.size) || bad_op) begin
                    res_resp_d = RESP_SLVERR;
                end
            end
            ST_REQ: cnt_d = '0;
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion arriving on the timeout cycle still counts as a completion.
                if (ram_rvalid) begin
                    res_resp_d = ram_err ? RESP_SLVERR : RESP_OKAY;
                    res_data_d = (txn_q.op == REQ_WRITE) ? '0 : lane_rdata;
                end else if (timed_out) begin
                    res_resp_d = RESP_SLVERR;
                    res_data_d = '0;
                end
            end
            ST_RESP: begin
                last_d = txn_q.port;
                if (txn_q.port == PORT_IF) begin
                    if_resp_d = res_resp_q;
                    if_data_d = res_data_q;
                end else begin
                    mem_resp_d = res_resp_q;
                    mem_data_d = res_data_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= PORT_IF;
            txn_q      <= '0;
            cnt_q      <= '0;
            res_resp_q <= '0;
            res_data_q <= '0;
            if_resp_q  <= '0;
            if_data_q  <= '0;
            mem_resp_q <= '0;
            mem_data_q <= '0;
        end else begin
            last_q     <= last_d;
            txn_q      <= txn_d;
            cnt_q      <= cnt_d;
            res_resp_q <= res_resp_d;
            res_data_q <= res_data_d;
            if_resp_q  <= if_resp_d;
            if_data_q  <= if_data_d;
            mem_resp_q <= mem_resp_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Port outputs show the fresh result during the ready pulse and the held copy otherwise.
    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (state_q == ST_REQ) begin
            ram_req   = 1'b1;
            ram_we    = (txn_q.op == REQ_WRITE);
            ram_addr  = {txn_q.addr[63:3], 3'b000};
            ram_wdata = lane_wdata;
            ram_wstrb = lane_strb;
        end
        if_ready      = (state_q == ST_RESP) && (txn_q.port == PORT_IF);
        mem_ready     = (state_q == ST_RESP) && (txn_q.port == PORT_MEM);
        if_resp       = if_ready  ? res_resp_q : if_resp_q;
        if_data_read  = if_ready  ? res_data_q : if_data_q;
        mem_resp      = mem_ready ? res_resp_q : mem_resp_q;
        mem_data_read = mem_ready ? res_data_q : mem_data_q;
    end

endmodule

// File: tb/tb_core_bus_responder.sv
// Scoreboard bench for core_bus_responder with a reactive RAM backend model.
module tb_core_bus_responder;

    logic        clk, rst;
    logic        if_valid, if_ready;
    logic [63:0] if_addr, if_data_read;
    logic [1:0]  if_size, if_resp;
    logic        mem_valid, mem_ready;
    logic [1:0]  mem_req, mem_size, mem_resp;
    logic [63:0] mem_addr, mem_data_write, mem_data_read;
    logic        ram_req, ram_we, ram_gnt, ram_rvalid, ram_err;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;
    logic [7:0]  ram_wstrb;

    typedef struct packed {
        logic        port;
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic [1:0]  req;
        logic [1:0]  resp;
        logic [63:0] data;
        int          lat;
    } vec_t;

    exp_t        sbq[$];
    int          total = 0, bad = 0, n_if = 0, n_mem = 0;
    logic        rv_en, err_cfg, saw_req;
    int          rv_lat, rv_wait;
    logic        pend;
    logic [63:0] rd_cfg, cap_addr, cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_we;

    core_bus_responder dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
        .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_write(mem_data_write), .mem_size(mem_size),
        .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid),
        .ram_rdata(ram_rdata), .ram_err(ram_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_gnt = ram_req;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic score(input logic port, input logic [1:0] resp, input logic [63:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("spurious_ready", 64'(1), 64'(0));
        end else begin
            e = sbq.pop_front();
            chk("sb_port", 64'(port), 64'(e.port));
            chk("sb_resp", 64'(resp), 64'(e.resp));
            chk("sb_data", data, e.data);
        end
    endtask

    // Backend: accepts on the request cycle, answers rv_lat cycles into WAIT.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            pend = 1'b0; ram_rvalid = 1'b0; ram_err = 1'b0; ram_rdata = '0; rv_wait = 0;
        end else begin
            ram_rvalid = 1'b0;
            ram_err    = 1'b0;
            if (pend) begin
                if (rv_wait == 0) begin
                    ram_rvalid = 1'b1; ram_err = err_cfg; ram_rdata = rd_cfg; pend = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            if (ram_req && ram_gnt && rv_en) begin
                pend = 1'b1; rv_wait = rv_lat;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ram_req && ram_gnt) begin
                saw_req = 1'b1; cap_addr = ram_addr; cap_wdata = ram_wdata;
                cap_wstrb = ram_wstrb; cap_we = ram_we;
            end
            if (if_ready && mem_ready) chk("dual_ready", 64'(1), 64'(0));
            if (if_ready)  begin n_if++;  score(1'b0, if_resp, if_data_read); end
            if (mem_ready) begin n_mem++; score(1'b1, mem_resp, mem_data_read); end
        end
    end

    task automatic run(input logic port, input logic [63:0] addr, input logic [1:0] size,
                       input logic [1:0] req, input logic [63:0] wd,
                       input logic [1:0] eresp, input logic [63:0] edata, output int lat);
        exp_t e;
        logic done;
        @(negedge clk);
        e.port = port; e.resp = eresp; e.data = edata;
        sbq.push_back(e);
        saw_req = 1'b0;
        lat = 0;
        done = 1'b0;
        if (port) begin
            mem_valid = 1'b1; mem_addr = addr; mem_size = size; mem_req = req; mem_data_write = wd;
        end else begin
            if_valid = 1'b1; if_addr = addr; if_size = size;
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            lat++;
            done = port ? mem_ready : if_ready;
        end
        if (!done) chk("ready_timeout", 64'(0), 64'(1));
        if_valid  = 1'b0;
        mem_valid = 1'b0;
    endtask

    vec_t tbl[8];
    int   lat, if0, mem0;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_valid = 0; if_addr = '0; if_size = '0;
        mem_valid = 0; mem_req = '0; mem_addr = '0; mem_data_write = '0; mem_size = '0;
        rv_en = 1'b1; err_cfg = 1'b0; rv_lat = 0; rd_cfg = '0; saw_req = 0;
        cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 0;
        repeat (3) @(negedge clk);
        chk("rst_if", {61'd0, if_ready, if_resp}, 64'(0));
        chk("rst_mem", {61'd0, mem_ready, mem_resp}, 64'(0));
        chk("rst_ram", {46'd0, ram_req, ram_we, ram_wstrb, ram_addr[7:0]}, 64'(0));
        rst = 1'b1;

        // Store half-word to lanes 2..3.
        run(1'b1, 64'h8000_0002, 2'b01, 2'b01, 64'hBEEF, 2'b00, 64'h0, lat);
        chk("st_lat", 64'(lat), 64'(4));
        chk("st_wstrb", 64'(cap_wstrb), 64'(8'b0000_1100));
        chk("st_wdata", cap_wdata, 64'h0000_0000_BEEF_0000);
        chk("st_addr", cap_addr, 64'h8000_0000);
        chk("st_we", 64'(cap_we), 64'(1));

        // Fetch word at offset 4.
        rd_cfg = 64'h1234_5678_0000_0013;
        run(1'b0, 64'h8000_0004, 2'b10, 2'b00, 64'h0, 2'b00, 64'h0000_0000_1234_5678, lat);
        chk("if_lat", 64'(lat), 64'(4));
        chk("if_we", 64'(cap_we), 64'(0));

        // Both ports together, twice: MEM wins each round since IF was served last.
        rd_cfg = 64'h1122_3344_5566_7788;
        for (int r = 0; r < 2; r++) begin
            exp_t e;
            @(negedge clk);
            e.port = 1'b1; e.resp = 2'b00; e.data = 64'h0000_0000_5566_7788; sbq.push_back(e);
            e.port = 1'b0; e.resp = 2'b00; e.data = 64'h1122_3344_5566_7788; sbq.push_back(e);
            if0 = n_if; mem0 = n_mem;
            if_valid = 1'b1; if_addr = 64'h8000_0010; if_size = 2'b11;
            mem_valid = 1'b1; mem_addr = 64'h8000_0020; mem_size = 2'b10; mem_req = 2'b00;
            for (int i = 0; i < 40 && (if_valid || mem_valid); i++) begin
                @(negedge clk);
                if (mem_ready) mem_valid = 1'b0;
                if (if_ready)  if_valid  = 1'b0;
            end
            if_valid = 1'b0; mem_valid = 1'b0;
            #1;
            chk("rr_if_cnt", 64'(n_if - if0), 64'(1));
            chk("rr_mem_cnt", 64'(n_mem - mem0), 64'(1));
        end

        // Window / alignment / opcode boundaries on the data port.
        tbl[0] = '{64'h7FFF_FFF8, 2'b11, 2'b00, 2'b11, 64'h0, 2};
        tbl[1] = '{64'h8000_0003, 2'b10, 2'b00, 2'b10, 64'h0, 2};
        tbl[2] = '{64'h7FFF_FFF9, 2'b11, 2'b00, 2'b11, 64'h0, 2};
        tbl[3] = '{64'h8800_0000, 2'b00, 2'b00, 2'b11, 64'h0, 2};
        tbl[4] = '{64'h87FF_FFFF, 2'b00, 2'b00, 2'b00, 64'h11, 4};
        tbl[5] = '{64'h8000_0000, 2'b11, 2'b10, 2'b10, 64'h0, 2};
        tbl[6] = '{64'h8000_0006, 2'b01, 2'b00, 2'b00, 64'h1122, 4};
        tbl[7] = '{64'h8000_0005, 2'b01, 2'b11, 2'b10, 64'h0, 2};
        for (int k = 0; k < 8; k++) begin
            run(1'b1, tbl[k].addr, tbl[k].size, tbl[k].req, 64'h0, tbl[k].resp, tbl[k].data, lat);
            chk("vec_lat", 64'(lat), 64'(tbl[k].lat));
            chk("vec_ramreq", 64'(saw_req), 64'(tbl[k].resp == 2'b00));
        end

        // Backend error and backend silence.
        err_cfg = 1'b1;
        run(1'b1, 64'h8000_0008, 2'b11, 2'b00, 64'h0, 2'b10, 64'h1122_3344_5566_7788, lat);
        chk("err_lat", 64'(lat), 64'(4));
        err_cfg = 1'b0;
        rv_en = 1'b0;
        run(1'b1, 64'h8000_0008, 2'b11, 2'b00, 64'h0, 2'b10, 64'h0, lat);
        chk("to_lat", 64'(lat), 64'(2 + 256));

        // Asynchronous reset while waiting on the backend.
        @(negedge clk);
        if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'b11;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_if", {61'd0, if_ready, if_resp}, 64'(0));
        chk("arst_if_data", if_data_read, 64'(0));
        chk("arst_mem_data", mem_data_read, 64'(0));
        chk("arst_ram", {55'd0, ram_req, ram_wstrb}, 64'(0));
        if_valid = 1'b0;
        rv_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        rd_cfg = 64'hCAFE_F00D_DEAD_BEEF;
        run(1'b0, 64'h8000_0000, 2'b11, 2'b00, 64'h0, 2'b00, 64'hCAFE_F00D_DEAD_BEEF, lat);
        chk("post_rst_lat", 64'(lat), 64'(4));

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_bus_responder.md
Name: core_bus_responder

Overview:
- Slave-side responder for the core's two request ports: instruction fetch (if_*) and data access (mem_*).
- Arbitrates between the ports and services one transaction at a time on a 64-bit word-addressed RAM backend with a req/gnt/rvalid handshake.
- Returns ready/resp/data to the requesting port.
- Sits between the CPU top and the memory/SoC fabric.

Parameters:
- ADDR_BASE, 64'h0000_0000_8000_0000, first legal byte address.
- ADDR_SIZE, 64'h0000_0000_0800_0000, legal window size in bytes.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- if_valid  in  1  fetch request; held until if_ready.
- if_addr  in  64  fetch byte address.
- if_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- if_data_read  out  64  fetch data, right-justified.
- mem_valid  in  1  data request; held until mem_ready.
- mem_req  in  2  00 read, 01 write; other codes read as SLVERR.
- mem_addr  in  64  data byte address.
- mem_data_write  in  64  store data, right-justified.
- mem_size  in  2  same encoding as if_size.
- mem_ready  out  1  one-cycle completion pulse for data.
- mem_resp  out  2  same encoding as if_resp.
- mem_data_read  out  64  load data, right-justified.
- ram_req  out  1  backend request.
- ram_we  out  1  backend write.
- ram_addr  out  64  backend address, bits [2:0] are 0.
- ram_wdata  out  64  lane-aligned write data.
- ram_wstrb  out  8  byte strobes.
- ram_gnt  in  1  backend accepts request this cycle.
- ram_rvalid  in  1  backend completion.
- ram_rdata  in  64  backend read data, lane-aligned.
- ram_err  in  1  backend error, qualified by ram_rvalid.

Behaviour:
- Reset: state=IDLE; all outputs 0; last_grant=IF.
- FSM states: IDLE, CHECK, REQ, WAIT, RESP.
- IDLE:
  - Only if_valid asserted → grant IF. Only mem_valid asserted → grant MEM.
  - Both asserted → grant the port not granted last (round-robin).
  - On grant: latch port, addr, size, op (IF always read), and wdata; go to CHECK.
  - No request → stay in IDLE.
- CHECK (1 cycle):
  - addr outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) → resp DECERR, go to RESP.
  - addr not aligned to 2^size, or illegal mem_req → resp SLVERR, go to RESP.
  - Otherwise go to REQ.
  - Address-window check takes precedence over alignment check.
  - Error responses make no backend access.
- REQ:
  - ram_req=1; ram_addr={addr[63:3],3'b0}; ram_we=op.
  - ram_wstrb = ((1<<2^size)-1) << addr[2:0].
  - ram_wdata = wdata << (addr[2:0]*8).
  - Hold all ram_* outputs stable until ram_gnt; on gnt go to WAIT with timeout counter cleared.
- WAIT:
  - ram_req=0; counter increments each cycle.
  - ram_rvalid → capture rdata>>(addr[2:0]*8), masked to size width; resp = ram_err ? SLVERR : OKAY; go to RESP.
  - Writes return data 0.
  - Counter reaches TIMEOUT → resp SLVERR, data 0, go to RESP.
  - ram_rvalid in the same cycle as timeout: ram_rvalid wins.
- RESP:
  - Pulse the granted port's ready for exactly 1 cycle, with resp and data valid that cycle.
  - Update last_grant; go to IDLE.
  - Response is issued even if the requester dropped valid (flush); the requester ignores it.
- Output hold rules:
  - data_read and resp outputs hold their value until the port's next response.
  - The non-granted port's ready stays 0.
- Timing:
  - Best-case latency from valid sampled in IDLE to ready = 4 cycles (IDLE, CHECK, REQ with same-cycle gnt, WAIT with rvalid next, RESP).
  - Error latency = 2 cycles after grant.
- Async reset mid-transaction: return to IDLE immediately, drop ram_req, no ready pulse. The backend is reset by the same rst.

Decomposition:
- Shared package holds:
  - RESP_OKAY/SLVERR/DECERR.
  - REQ_READ/REQ_WRITE.
  - SIZE_B/H/W/D.
  - FSM state enum.
  - 64-bit bus width constant (alongside the existing REG_BUS definitions).
- One sub-module, bus_lane_align: combinational strobe generation, write shift, and read extract/mask from addr[2:0] and size.

Test Plan:
- Fetch 0x8000_0004 size 10; backend returns ram_rdata 0x1234_5678_0000_0013 one cycle after gnt → if_ready pulse, if_resp 00, if_data_read 0x0000_0000_1234_5678.
- Store mem_addr 0x8000_0002 size 01 data 0xBEEF → ram_wstrb 8'b0000_1100, ram_wdata 0x0000_0000_BEEF_0000, mem_ready with resp 00.
- if_valid and mem_valid asserted together twice in a row with last_grant=IF → MEM served first, then IF; each port gets exactly one ready.
- Load mem_addr 0x7FFF_FFF8 → mem_resp 11, no ram_req. Load 0x8000_0003 size 10 → mem_resp 10, no ram_req.
- TIMEOUT=255 and backend never asserts rvalid → mem_resp 10 exactly 256 cycles after gnt. ram_err=1 with rvalid → resp 10.
- rst driven low while in WAIT → all outputs 0 asynchronously; a new fetch after release completes normally.
